// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter that shares the single framebuffer pixel write port among
// three drawing engines (0 clear, 1 trace, 2 overlay), granting whole bursts capped at MAX_BURST beats.
module fb_write_arbiter #(
    parameter int MAX_BURST = 256,
    parameter int CW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [2:0]  valid,
    input  logic [2:0]  last,
    input  logic [23:0] px_x,
    input  logic [23:0] px_y,
    input  logic [35:0] px_color,
    output logic [2:0]  gnt,
    output logic [7:0]  CounterX,
    output logic [7:0]  CounterY,
    output logic [11:0] color,
    output logic        we,
    output logic        busy
);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

    state_t          state_q, state_d;
    logic [1:0]      own_q, own_d;
    logic [1:0]      last_owner_q, last_owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            we_q, we_d;
    logic [7:0]      x_q, x_d, y_q, y_d;
    logic [11:0]     c_q, c_d;

    logic [2:0][7:0]  xs, ys;
    logic [2:0][11:0] cs;
    assign xs = px_x;
    assign ys = px_y;
    assign cs = px_color;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    logic       rel;
    logic [1:0] base, c1, c2, win;

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        we_d         = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        c_d          = c_q;
        rel          = 1'b0;
        base         = last_owner_q;

        if (state_q == S_OWN) begin
            // Dropping req abandons the burst; valid is not looked at that cycle.
            if (!req[own_q]) begin
                rel = 1'b1;
            end else if (valid[own_q]) begin
                we_d  = 1'b1;
                x_d   = xs[own_q];
                y_d   = ys[own_q];
                c_d   = cs[own_q];
                cnt_d = cnt_q + CW'(1);
                if (last[own_q] || cnt_q == CAP) rel = 1'b1;
            end
            if (rel) begin
                last_owner_d = own_q;
                base         = own_q;
            end
        end

        // Search order base+1, base+2, base: the releasing owner is considered last.
        c1  = inc3(base);
        c2  = inc3(c1);
        win = req[c1] ? c1 : (req[c2] ? c2 : base);

        if (state_q == S_IDLE || rel) begin
            cnt_d = '0;
            if (|req) begin
                state_d = S_OWN;
                own_d   = win;
                gnt_d   = 3'b001 << win;
            end else begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
        end
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            own_q        <= 2'd0;
            last_owner_q <= 2'd2;
            cnt_q        <= '0;
            gnt_q        <= 3'b000;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            c_q          <= 12'd0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            x_q          <= x_d;
            y_q          <= y_d;
            c_q          <= c_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign we       = we_q;
    assign CounterX = x_q;
    assign CounterY = y_q;
    assign color    = c_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scenario tests plus a randomized run against a burst-level reference model of the write arbiter.
module tb_fb_write_arbiter;

    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, valid, last;
    logic [23:0] px_x, px_y;
    logic [35:0] px_color;
    logic [2:0]  gnt;
    logic [7:0]  CounterX, CounterY;
    logic [11:0] color;
    logic        we, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fb_write_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .valid(valid), .last(last),
        .px_x(px_x), .px_y(px_y), .px_color(px_color),
        .gnt(gnt), .CounterX(CounterX), .CounterY(CounterY), .color(color),
        .we(we), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input int i, input logic r, input logic v, input logic l,
                           input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
        req[i]              = r;
        valid[i]            = v;
        last[i]             = l;
        px_x[i*8 +: 8]      = x;
        px_y[i*8 +: 8]      = y;
        px_color[i*12 +: 12] = c;
    endtask

    task automatic idle_all();
        req   = 3'b000;
        valid = 3'b000;
        last  = 3'b000;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b111;
        valid = 3'b111;
        repeat (3) tick();
        n_cmp++;
        if ({gnt, we, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/we/busy=%b expected 00000", {gnt, we, busy});
        end
        n_cmp++;
        if ({CounterX, CounterY, color} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_data: x=%h y=%h c=%h expected 0", CounterX, CounterY, color);
        end
        valid = 3'b000;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 3'b001 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b busy=%b expected 001/1", gnt, busy);
        end
        req = 3'b000;
        tick();
        n_cmp++;
        if (gnt !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: gnt=%b busy=%b expected 000/0", gnt, busy);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        set_eng(1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        tick();
        n_cmp++;
        if (gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%b expected 010", gnt);
        end
        for (int b = 0; b < 4; b++) begin
            set_eng(1, 1'b1, 1'b1, b == 3, 8'(10 + b), 8'd5, 12'hF00);
            tick();
            n_cmp++;
            if (we !== 1'b1 || CounterX !== 8'(10 + b) || CounterY !== 8'd5 || color !== 12'hF00) begin
                n_fail++;
                $display("FAIL single_beat%0d: we=%b x=%0d y=%0d c=%h expected 1/%0d/5/f00",
                         b, we, CounterX, CounterY, color, 10 + b);
            end
        end
        set_eng(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        tick();
        n_cmp++;
        if (we !== 1'b0 || gnt !== 3'b000 || CounterX !== 8'd13 || color !== 12'hF00) begin
            n_fail++;
            $display("FAIL single_end: we=%b gnt=%b x=%0d c=%h expected 0/000/13/f00",
                     we, gnt, CounterX, color);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
        logic [7:0] exp_x [6] = '{8'd0, 8'd1, 8'd16, 8'd17, 8'd32, 8'd33};
        int  cnt  [3] = '{0, 0, 0};
        bit  done [3] = '{0, 0, 0};
        do_reset();
        req = 3'b111;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++;
            if (gnt !== exp_g[k-1]) begin
                n_fail++;
                $display("FAIL rr_gnt cycle %0d: gnt=%b expected %b", k, gnt, exp_g[k-1]);
            end
            n_cmp++;
            if (we !== (k >= 2) || (k >= 2 && CounterX !== exp_x[k-2])) begin
                n_fail++;
                $display("FAIL rr_write cycle %0d: we=%b x=%0d expected we=%0d x=%0d",
                         k, we, CounterX, k >= 2, (k >= 2) ? exp_x[k-2] : 8'd0);
            end
            for (int i = 0; i < 3; i++) begin
                if (done[i]) req[i] = 1'b0;
                if (gnt[i]) begin
                    set_eng(i, req[i], 1'b1, cnt[i] == 1, 8'(i*16 + cnt[i]), 8'(i), 12'(i));
                    cnt[i]++;
                    if (cnt[i] == 2) begin
                        cnt[i] = 0;
                        if (i != 0) done[i] = 1'b1;
                    end
                end else begin
                    valid[i] = 1'b0;
                    last[i]  = 1'b0;
                end
            end
        end
        idle_all();
        tick();
    endtask

    task automatic test_burst_cap();
        int b = 0;
        int writes = 0;
        do_reset();
        set_eng(0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        set_eng(2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (we) writes++;
            n_cmp++;
            if (gnt !== ((k <= MB) ? 3'b001 : 3'b100)) begin
                n_fail++;
                $display("FAIL cap_gnt cycle %0d: gnt=%b expected %b", k, gnt,
                         (k <= MB) ? 3'b001 : 3'b100);
            end
            n_cmp++;
            if (we !== (k >= 2 && k <= MB + 1) || (we && CounterX !== 8'(k - 2))) begin
                n_fail++;
                $display("FAIL cap_write cycle %0d: we=%b x=%0d expected we=%0d x=%0d",
                         k, we, CounterX, k >= 2 && k <= MB + 1, k - 2);
            end
            if (gnt[0] && b < 20) begin
                set_eng(0, 1'b1, 1'b1, 1'b0, 8'(b), 8'd1, 12'h0A0);
                b++;
            end
        end
        n_cmp++;
        if (writes != MB) begin
            n_fail++;
            $display("FAIL cap_count: writes=%0d expected %0d", writes, MB);
        end
        idle_all();
        tick();
    endtask

    task automatic test_abandon();
        do_reset();
        set_eng(2, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        set_eng(0, 1'b0, 1'b1, 1'b0, 8'hAA, 8'hAA, 12'hAAA);
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++;
            if (gnt !== ((k <= 4) ? 3'b100 : 3'b010)) begin
                n_fail++;
                $display("FAIL abandon_gnt cycle %0d: gnt=%b expected %b", k, gnt,
                         (k <= 4) ? 3'b100 : 3'b010);
            end
            n_cmp++;
            if (we !== (k >= 2 && k <= 4) || CounterX !== 8'((k <= 4) ? k - 2 : 2) && k >= 2
                || (we && (CounterY === 8'hAA || color === 12'hAAA))) begin
                n_fail++;
                $display("FAIL abandon_write cycle %0d: we=%b x=%h y=%h c=%h", k, we,
                         CounterX, CounterY, color);
            end
            set_eng(1, 1'b1, k <= 4, 1'b0, 8'hAA, 8'hAA, 12'hAAA);
            if (k <= 3)       set_eng(2, 1'b1, 1'b1, 1'b0, 8'(k - 1), 8'd2, 12'h00F);
            else if (k == 4)  set_eng(2, 1'b0, 1'b1, 1'b0, 8'd99, 8'd2, 12'h00F);
            else              set_eng(2, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_eng(1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 12'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                n_cmp++;
                if (gnt !== 3'b010) begin
                    n_fail++;
                    $display("FAIL mid_grant: gnt=%b expected 010", gnt);
                end
            end else begin
                n_cmp++;
                if (we !== 1'b1 || CounterX !== 8'(k - 2)) begin
                    n_fail++;
                    $display("FAIL mid_beat cycle %0d: we=%b x=%0d expected 1/%0d", k, we, CounterX, k - 2);
                end
            end
            set_eng(1, 1'b1, 1'b1, 1'b0, 8'(k - 1), 8'd7, 12'h777);
            if (k == 5) rst_n = 1'b0;
        end
        tick();
        n_cmp++;
        if (we !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0 || CounterX !== 8'd0 || color !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset: we=%b gnt=%b busy=%b x=%0d c=%h expected 0/000/0/0/0",
                     we, gnt, busy, CounterX, color);
        end
        rst_n = 1'b1;
        req   = 3'b111;
        valid = 3'b000;
        tick();
        n_cmp++;
        if (gnt !== 3'b001 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_regrant: gnt=%b we=%b expected 001/0", gnt, we);
        end
        idle_all();
        tick();
    endtask

    task automatic test_random();
        int owner = -1, lo = 2, beats = 0;
        logic [2:0]  eg = 3'b000;
        logic        ewe = 1'b0;
        logic [7:0]  ex = 8'd0, ey = 8'd0;
        logic [11:0] ec = 12'd0;
        bit rel;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(199) != 0);
            for (int i = 0; i < 3; i++) begin
                if (req[i]) req[i] = ($urandom_range(15) != 0);
                else        req[i] = ($urandom_range(2) == 0);
                valid[i] = ($urandom_range(3) != 0);
                last[i]  = ($urandom_range(5) == 0);
                px_x[i*8 +: 8]       = 8'($urandom);
                px_y[i*8 +: 8]       = 8'($urandom);
                px_color[i*12 +: 12] = 12'($urandom);
            end
            // Reference: owner holds the port until last, MB beats, or req drop.
            if (!rst_n) begin
                owner = -1; lo = 2; beats = 0; ewe = 1'b0;
                ex = 8'd0; ey = 8'd0; ec = 12'd0;
            end else begin
                ewe = 1'b0;
                rel = (owner < 0);
                if (owner >= 0) begin
                    if (!req[owner]) rel = 1'b1;
                    else if (valid[owner]) begin
                        ewe = 1'b1;
                        ex  = px_x[owner*8 +: 8];
                        ey  = px_y[owner*8 +: 8];
                        ec  = px_color[owner*12 +: 12];
                        beats++;
                        if (last[owner] || beats == MB) rel = 1'b1;
                    end
                    if (rel) lo = owner;
                end
                if (rel) begin
                    owner = -1;
                    beats = 0;
                    for (int s = 1; s <= 3; s++)
                        if (owner < 0 && req[(lo + s) % 3]) owner = (lo + s) % 3;
                end
            end
            eg = (owner < 0) ? 3'b000 : 3'(1 << owner);
            tick();
            n_cmp++;
            if ({gnt, busy, we} !== {eg, |eg, ewe}) begin
                n_fail++;
                $display("FAIL rand_ctrl step %0d: gnt=%b busy=%b we=%b expected %b/%b/%b",
                         n, gnt, busy, we, eg, |eg, ewe);
            end
            n_cmp++;
            if ({CounterX, CounterY, color} !== {ex, ey, ec}) begin
                n_fail++;
                $display("FAIL rand_data step %0d: x=%h y=%h c=%h expected %h/%h/%h",
                         n, CounterX, CounterY, color, ex, ey, ec);
            end
        end
        rst_n = 1'b1;
        idle_all();
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 3'b000;
        valid    = 3'b000;
        last     = 3'b000;
        px_x     = '0;
        px_y     = '0;
        px_color = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_burst_cap();
        test_abandon();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer pixel write port (CounterX/CounterY/color) among three drawing engines: slot 0 clear, slot 1 trace, slot 2 overlay. Requesters own the port for whole bursts under round-robin arbitration. A MAX_BURST cap stops one engine from starving the others. The block sits between the drawing engines and the framebuffer write logic, and replaces hard-wired state-based muxing. Its outputs are always driven and registered, so there is no tri-state.

## Interface
- MAX_BURST, default 256 — beats a requester may write per grant before forced release; legal range 1..65536
- CW, default clog2(MAX_BURST) — width of the internal beat counter; derived, do not override
- clk  in  1  — single clock, all logic on rising edge
- rst_n  in  1  — synchronous, active-low reset
- req  in  3  — req[i]: engine i wants the port; held high for the whole burst
- valid  in  3  — valid[i]: engine i presents a pixel beat this cycle
- last  in  3  — last[i]: the beat on engine i is the final beat of its burst; qualified by valid[i]
- px_x  in  24  — {x2,x1,x0}, 8 bits per engine
- px_y  in  24  — {y2,y1,y0}, 8 bits per engine
- px_color  in  36  — {c2,c1,c0}, 12 bits per engine
- gnt  out  3  — registered grant, one-hot or zero
- CounterX  out  8  — registered write address X
- CounterY  out  8  — registered write address Y
- color  out  12  — registered write data
- we  out  1  — write strobe; CounterX/CounterY/color are valid when high
- busy  out  1  — high when any gnt bit is set

## Operation
- States:
  - IDLE: no owner.
  - OWN: exactly one gnt bit set; owner index `own`.
- Round-robin search order starts at (last_owner+1) mod 3. last_owner resets to 2, so engine 0 wins the first arbitration after reset.
- IDLE:
  - If any req bit is high, pick the winner by search order, set gnt to that bit, go to OWN, clear the beat counter.
  - If no req bit is high, stay in IDLE with gnt=0.
- OWN, per cycle:
  - Beat accept: accept = req[own] & valid[own]. On accept, register px_x/px_y/px_color slice `own` into CounterX/CounterY/color and set we=1 for the next cycle. Increment the beat counter.
  - Release conditions, any one of:
    - (a) accept & last[own];
    - (b) accept and the counter reaches MAX_BURST-1 (the cap), giving exactly MAX_BURST beats;
    - (c) req[own]=0. This abandons the burst; valid[own] is ignored that cycle.
  - On release, last_owner <= own, then re-arbitrate using the same cycle's req vector:
    - Other engines requesting: grant the first one in search order.
    - Only the releasing engine still requesting: regrant it. The counter clears, so a capped engine continues in a new grant.
    - No requests: go to IDLE.
- Non-owner valid/last inputs are ignored. No beat is ever lost or duplicated for the owner.
- Idle outputs: when no beat is accepted, we=0 on the next cycle and CounterX/CounterY/color hold their last values.
- Reset (rst_n=0 at an edge) values: gnt=0, we=0, busy=0, CounterX=0, CounterY=0, color=0, state IDLE, last_owner=2, counter=0.
- Reset mid-burst: any in-flight beat is discarded, there is no write for the reset cycle, and the burst is not resumed.

## Timing
- req[i] rises at cycle t in IDLE → gnt[i]=1 at t+1.
- A beat accepted at cycle a → we=1 with its data at a+1. Write latency is 1 cycle; back-to-back beats give continuous we.
- Release decided at cycle r → old gnt bit low at r+1. The new gnt bit is high at r+1 with no bubble cycle; its first beat can be accepted at r+1.
- Simultaneous req rises in IDLE: a single winner by search order. The losers stay pending with no timeout.
- busy = |gnt; it is registered with gnt, not a combinational OR of req.
- Worst-case wait for a pending engine: 2 × MAX_BURST beat cycles plus stalls.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=3'b111 → gnt=0, we=0, CounterX=CounterY=color=0. First edge with rst_n=1 → gnt=3'b001 at the following cycle.
- Single burst: engine 1 writes 4 beats (x=10..13, y=5, color=12'hF00), last on beat 4 → we high 4 consecutive cycles, each 1 cycle after its beat, with matching data; gnt=0 the cycle after the last beat.
- Round-robin: all three engines request, each with a 2-beat burst → grant order 0,1,2 with no idle cycle between owners. Engine 0 re-requests → it is granted after engine 2.
- Burst cap: MAX_BURST=8; engine 0 streams 20 beats with no last while engine 2 requests → exactly 8 writes from engine 0, then gnt=3'b100.
- Abandon and ignore: engine 2 drops req after 3 beats while valid=1 → no 4th write, immediate handoff. Non-owner valid with distinct data → no write ever carries its data.
- Reset mid-burst: assert rst_n=0 during beat 5 of a 10-beat burst → we=0 and gnt=0 the next cycle, no further writes. After release, engine 0 wins even if the interrupted owner was 1.
